// File: rtl/sine_cos_pkg.sv
// Shared constants, types and the quarter-wave sine table for the sine_cos generator.
package sine_cos_pkg;

  localparam int PHASE_W = 8;
  localparam int DATA_W  = 8;
  localparam int AMP     = 127;
  localparam int QUARTER = 64;

  typedef logic        [PHASE_W-1:0] phase_t;
  typedef logic signed [DATA_W-1:0]  sample_t;

  typedef enum logic [1:0] {
    Q_RISE     = 2'd0,
    Q_FALL     = 2'd1,
    Q_NEG_RISE = 2'd2,
    Q_NEG_FALL = 2'd3
  } quadrant_t;

  // round(127 * sin(2*pi*i/256)), half away from zero, i = 0..64
  localparam sample_t QTABLE [0:QUARTER] = '{
    8'sd0,   8'sd3,   8'sd6,   8'sd9,   8'sd12,  8'sd16,  8'sd19,  8'sd22,
    8'sd25,  8'sd28,  8'sd31,  8'sd34,  8'sd37,  8'sd40,  8'sd43,  8'sd46,
    8'sd49,  8'sd51,  8'sd54,  8'sd57,  8'sd60,  8'sd63,  8'sd65,  8'sd68,
    8'sd71,  8'sd73,  8'sd76,  8'sd78,  8'sd81,  8'sd83,  8'sd85,  8'sd88,
    8'sd90,  8'sd92,  8'sd94,  8'sd96,  8'sd98,  8'sd100, 8'sd102, 8'sd104,
    8'sd106, 8'sd107, 8'sd109, 8'sd111, 8'sd112, 8'sd113, 8'sd115, 8'sd116,
    8'sd117, 8'sd118, 8'sd120, 8'sd121, 8'sd122, 8'sd122, 8'sd123, 8'sd124,
    8'sd125, 8'sd125, 8'sd126, 8'sd126, 8'sd126, 8'sd127, 8'sd127, 8'sd127,
    8'sd127
  };

  localparam sample_t RST_SINE = sample_t'(0);
  localparam sample_t RST_COS  = sample_t'(AMP);

  // Offset-binary form: flipping the sign bit adds 128.
  function automatic logic [DATA_W-1:0] to_offset(input sample_t s);
    return {~s[DATA_W-1], s[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/sine_cos_quarter_lut.sv
// Combinational full-wave sine lookup built from the 65-entry quarter-wave table.
module sine_cos_quarter_lut
  import sine_cos_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  output logic [DATA_W-1:0]  sample
);

  quadrant_t quad;
  logic [5:0] i;
  logic [6:0] idx;
  sample_t    mag;

  always_comb begin
    quad = quadrant_t'(phase[7:6]);
    i    = phase[5:0];
    idx  = {1'b0, i};
    unique case (quad)
      Q_FALL, Q_NEG_FALL: idx = 7'(QUARTER) - {1'b0, i};
      default:            idx = {1'b0, i};
    endcase
    mag = QTABLE[idx];
    unique case (quad)
      Q_NEG_RISE, Q_NEG_FALL: sample = -mag;
      default:                sample = mag;
    endcase
  end

endmodule

// File: rtl/sine_cos.sv
// Phase-accumulator sine/cosine generator with registered signed and offset-binary outputs.
// Define SINE_COS_OUTREG_EN to add a second output register stage (latency 2).
module sine_cos
  import sine_cos_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [DATA_W-1:0] sine,
  output logic [DATA_W-1:0] cos,
  output logic [DATA_W-1:0] sine_u,
  output logic [DATA_W-1:0] cos_u
);

  phase_t  p;
  phase_t  p_cos;
  sample_t lut_sine;
  sample_t lut_cos;
  sample_t fin_sine;
  sample_t fin_cos;

  assign p_cos = p + phase_t'(QUARTER);

  sine_cos_quarter_lut u_lut_sine (.phase(p),     .sample(lut_sine));
  sine_cos_quarter_lut u_lut_cos  (.phase(p_cos), .sample(lut_cos));

  always_ff @(posedge clk) begin
    if (reset)   p <= '0;
    else if (en) p <= p + phase_t'(STEP);
  end

`ifdef SINE_COS_OUTREG_EN
  sample_t s1_sine;
  sample_t s1_cos;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sine <= RST_SINE;
      s1_cos  <= RST_COS;
    end else if (en) begin
      s1_sine <= lut_sine;
      s1_cos  <= lut_cos;
    end
  end

  assign fin_sine = s1_sine;
  assign fin_cos  = s1_cos;
`else
  assign fin_sine = lut_sine;
  assign fin_cos  = lut_cos;
`endif

  // Offset outputs are registered alongside the signed ones rather than decoded after them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sine   <= RST_SINE;
      cos    <= RST_COS;
      sine_u <= to_offset(RST_SINE);
      cos_u  <= to_offset(RST_COS);
    end else if (en) begin
      sine   <= fin_sine;
      cos    <= fin_cos;
      sine_u <= to_offset(fin_sine);
      cos_u  <= to_offset(fin_cos);
    end
  end

endmodule

// File: tb/tb_sine_cos.sv
// Directed and sweep checks for sine_cos against hand values and a $sin reference.
module tb_sine_cos;

`ifdef SINE_COS_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] sine, cos, sine_u, cos_u;

  int tests = 0;
  int fails = 0;

  sine_cos #(.STEP(1)) dut (
    .clk(clk), .reset(reset), .en(en),
    .sine(sine), .cos(cos), .sine_u(sine_u), .cos_u(cos_u)
  );

  always #5 clk = ~clk;

  function automatic int s_of(input int ph);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * real'(ph % 256) / 256.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic int sv(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Reference pipeline: phase counter plus LAT sample stages, all gated by en.
  int mp = 0, mo1 = 0, mo2 = 0;
  int m1s = 0, m1c = 127, m2s = 0, m2c = 127;

  always @(posedge clk) begin
    if (reset) begin
      mp <= 0; mo1 <= 0; mo2 <= 0;
      m1s <= 0; m1c <= 127; m2s <= 0; m2c <= 127;
    end else if (en) begin
      mp  <= (mp + 1) % 256;
      mo1 <= mp;
      mo2 <= mo1;
      m1s <= s_of(mp);
      m1c <= s_of(mp + 64);
      m2s <= m1s;
      m2c <= m1c;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_s, exp_c, exp_ph, pwr;
  bit saw_wrap;

  initial begin
    tick(2);
    check("rst_sine",   sine,   8'h00);
    check("rst_cos",    cos,    8'h7F);
    check("rst_sine_u", sine_u, 8'h80);
    check("rst_cos_u",  cos_u,  8'hFF);

    reset = 1'b0;
    en    = 1'b1;
    tick(32 + LAT);
    check("p32_sine",   sine,   8'h5A);
    check("p32_cos",    cos,    8'h5A);
    check("p32_sine_u", sine_u, 8'hDA);

    tick(32);
    check("p64_sine", sv(sine), 127);
    check("p64_cos",  sv(cos),  0);

    tick(64);
    check("p128_sine",  sv(sine), 0);
    check("p128_cos",   cos,      8'h81);
    check("p128_cos_u", cos_u,    8'h01);

    tick(64);
    check("p192_sine",   sine,   8'h81);
    check("p192_sine_u", sine_u, 8'h01);
    check("p192_cos",    sv(cos), 0);

    tick(164);
    check("p100_sine", sv(sine), 81);
    check("p100_cos",  sv(cos),  -98);

    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("hold_sine",   sv(sine), 81);
      check("hold_cos",    sv(cos),  -98);
      check("hold_sine_u", sine_u,   209);
      check("hold_cos_u",  cos_u,    30);
    end

    en = 1'b1;
    tick(1);
    check("p101_sine", sv(sine), 78);

    saw_wrap = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick(1);
      exp_s  = (LAT == 2) ? m2s : m1s;
      exp_c  = (LAT == 2) ? m2c : m1c;
      exp_ph = (LAT == 2) ? mo2 : mo1;
      check("sweep_sine",   sv(sine), exp_s);
      check("sweep_cos",    sv(cos),  exp_c);
      check("sweep_sine_u", sine_u,   exp_s + 128);
      check("sweep_cos_u",  cos_u,    exp_c + 128);
      pwr = sv(sine) * sv(sine) + sv(cos) * sv(cos);
      check("sweep_power", int'(pwr >= 16129 - 254 && pwr <= 16129 + 254), 1);
      if (exp_ph == 0) begin
        saw_wrap = 1'b1;
        check("wrap_sine", sv(sine), 0);
      end
    end
    check("wrap_seen", int'(saw_wrap), 1);

    tick(5);
    check("p150_sine", sv(sine), -65);

    reset = 1'b1;
    tick(1);
    check("midrst_sine",   sine,   8'h00);
    check("midrst_cos",    cos,    8'h7F);
    check("midrst_sine_u", sine_u, 8'h80);
    check("midrst_cos_u",  cos_u,  8'hFF);

    reset = 1'b0;
    tick(LAT + 1);
    check("restart_sine", sv(sine), 3);
    check("restart_cos",  sv(cos),  127);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sine_cos.md
SINE_COS -- requirements
Module: sine_cos

Interface
REQ-001 Parameter: STEP, default 1, phase increment per enabled clock (1..64).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: en  input  1  advance enable; phase advances only on cycles with en=1.
REQ-005 Port: sine  output  8  two's-complement sine sample, range -127..+127.
REQ-006 Port: cos  output  8  two's-complement cosine sample, range -127..+127.
REQ-007 Port: sine_u  output  8  offset-binary sine, equal to sine + 128 (range 1..255).
REQ-008 Port: cos_u  output  8  offset-binary cosine, equal to cos + 128 (range 1..255).

Function
REQ-009 Internal 8-bit phase register p; one period equals 256 phase steps.
REQ-010 On a rising clk edge with reset=0 and en=1, p <= (p + STEP) mod 256; wrap-around from 255 to 0 is silent.
REQ-011 On a rising clk edge with reset=0 and en=0, p and all outputs hold their values.
REQ-012 Sample function: S(p) = round(127 * sin(2*pi*p/256)), where round means half away from zero.
REQ-013 sine shall equal S(p); cos shall equal S((p + 64) mod 256).
REQ-014 Quarter-wave table Q[i] = S(i) for i = 0..64 (65 entries; Q[0]=0, Q[32]=90, Q[64]=127).
REQ-015 Table mapping by quadrant, with q = p[7:6] and i = p[5:0]: q0 -> Q[i]; q1 -> Q[64-i]; q2 -> -Q[i]; q3 -> -Q[64-i].
REQ-016 sine_u and cos_u shall be the signed values with the MSB inverted.
REQ-017 All outputs are registered.
REQ-018 Latency: outputs reflect the phase value held in p one cycle earlier, i.e. one clock after the phase update (two clocks with the REQ-023 macro).
REQ-019 Outputs never take the value -128 (0x80), and the offset outputs never take 0.

Reset
REQ-020 reset has priority over en.
REQ-021 Reset values: p = 0, sine = 0x00, cos = 0x7F, sine_u = 0x80, cos_u = 0xFF.
REQ-022 A reset asserted mid-sweep forces the reset values on the next edge; with en=1 after reset is released, the sweep restarts from p = 0.

Configuration
REQ-023 Macro SINE_COS_OUTREG_EN defined: an additional output pipeline register stage is added, giving latency 2; that stage also loads the REQ-021 reset values.
REQ-024 Macro SINE_COS_OUTREG_EN undefined: latency is 1 and there is no extra stage.

Structure
REQ-025 Shared package sine_cos_pkg holds:
- PHASE_W = 8, DATA_W = 8, AMP = 127, QUARTER = 64
- the 65-entry quarter-wave table constant
- typedefs phase_t (8-bit unsigned) and sample_t (8-bit signed)
REQ-026 One sub-module, sine_cos_quarter_lut:
- combinational
- input: 8-bit phase
- output: 8-bit signed sample per REQ-015
- instantiated twice, once for sine (p) and once for cos (p + 64)

Verification
REQ-027 Reset held 2 cycles -> sine=0x00, cos=0x7F, sine_u=0x80, cos_u=0xFF.
REQ-028 Release reset, en=1, STEP=1, let p reach 32 -> sine=90 (0x5A), cos=90, sine_u=0xDA.
REQ-029 Let p reach 64, then 128, then 192:
- p=64 -> sine=127, cos=0
- p=128 -> sine=0, cos=-127 (0x81), cos_u=0x01
- p=192 -> sine=0x81, sine_u=0x01, cos=0
REQ-030 en=0 for 10 cycles at p=100 -> all outputs constant; en=1 -> advance resumes at p=101.
REQ-031 Run 300 cycles -> p wraps 255 -> 0 and sine returns to 0 at the wrap; every sample matches S(p), and sine^2 + cos^2 stays within 127^2 ± 254.
REQ-032 Assert reset at p=150 with en=1 -> the next edge shows the reset values; after release the sweep restarts at p=0.
